// File: rtl/snitch_icache_pkg.sv
// Shared types for the snitch instruction-cache refill path: refill-server FSM
// states and the line/beat geometry derived from the line and memory widths.
package snitch_icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } refill_server_state_e;

  typedef struct packed {
    int unsigned line_align;
    int unsigned beats;
    int unsigned beat_align;
  } refill_server_cfg_t;

  function automatic refill_server_cfg_t refill_server_cfg(input int unsigned line_width,
                                                           input int unsigned mem_dw);
    refill_server_cfg_t cfg;
    cfg.line_align = $clog2(line_width / 8);
    cfg.beats      = line_width / mem_dw;
    cfg.beat_align = $clog2(mem_dw / 8);
    return cfg;
  endfunction

endpackage

// File: rtl/snitch_icache_line_assembler.sv
// Collects in-order memory beats into one cache line: beat counter, slice
// write and sticky error accumulation. clear_i restarts a line.
module snitch_icache_line_assembler #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned MEM_DW     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  beat_valid_i,
  input  logic [MEM_DW-1:0]     beat_data_i,
  input  logic                  beat_error_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  error_o,
  output logic                  last_o
);

  localparam int unsigned BEATS = LINE_WIDTH / MEM_DW;
  localparam int unsigned CW    = $clog2(BEATS + 1);

  logic [CW-1:0]         cnt_q;
  logic                  error_q;
  logic [LINE_WIDTH-1:0] line_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else if (beat_valid_i) begin
      cnt_q   <= cnt_q + CW'(1);
      error_q <= error_q | beat_error_i;
    end
  end

  // Line storage is pure data: only the counter selects which slice is written.
  always_ff @(posedge clk_i) begin
    if (!clear_i && beat_valid_i) begin
      for (int b = 0; b < BEATS; b++) begin
        if (cnt_q == CW'(b)) line_q[b*MEM_DW +: MEM_DW] <= beat_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && beat_valid_i) assert (cnt_q < CW'(BEATS));
  end

  assign line_o  = line_q;
  assign error_o = error_q;
  assign last_o  = (cnt_q == CW'(BEATS - 1));

endmodule

// File: rtl/snitch_icache_l0_refill_server.sv
// Serves L0 line refills by fetching LINE_WIDTH/MEM_DW in-order beats.
// Optional 1-entry line buffer: define SNITCH_ICACHE_REFILL_LINE_BUF_EN.
module snitch_icache_l0_refill_server
  import snitch_icache_pkg::*;
#(
  parameter int unsigned FETCH_AW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned MEM_DW     = 32,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FETCH_AW-1:0]   in_req_addr_i,
  input  logic [ID_WIDTH-1:0]   in_req_id_i,
  input  logic                  in_req_valid_i,
  output logic                  in_req_ready_o,
  output logic [LINE_WIDTH-1:0] in_rsp_data_o,
  output logic                  in_rsp_error_o,
  output logic [ID_WIDTH-1:0]   in_rsp_id_o,
  output logic                  in_rsp_valid_o,
  input  logic                  in_rsp_ready_i,
  output logic [FETCH_AW-1:0]   mem_req_addr_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [MEM_DW-1:0]     mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  input  logic                  mem_rsp_valid_i,
  input  logic                  flush_i
);

  localparam refill_server_cfg_t CFG = refill_server_cfg(LINE_WIDTH, MEM_DW);
  localparam int unsigned LINE_ALIGN = CFG.line_align;
  localparam int unsigned BEATS      = CFG.beats;
  localparam int unsigned BEAT_ALIGN = CFG.beat_align;
  localparam int unsigned CW         = $clog2(BEATS + 1);
  localparam logic [FETCH_AW-1:0] LINE_MASK = ~((FETCH_AW'(1) << LINE_ALIGN) - FETCH_AW'(1));

  refill_server_state_e state_q, state_d;
  logic [FETCH_AW-1:0]   base_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [CW-1:0]         issue_cnt_q;
  logic                  from_buf_q;
  logic                  req_hs, mem_hs, beat_valid, beat_last, fill_done, hit;
  logic [LINE_WIDTH-1:0] line, buf_data;
  logic                  line_error;

  assign req_hs     = (state_q == IDLE) && in_req_valid_i;
  assign mem_hs     = mem_req_valid_o && mem_req_ready_i;
  assign beat_valid = (state_q == FETCH) && mem_rsp_valid_i;
  assign fill_done  = beat_valid && beat_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_req_valid_i) state_d = hit ? RESP : FETCH;
      FETCH:   if (fill_done) state_d = RESP;
      RESP:    if (in_rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      from_buf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        issue_cnt_q <= '0;
        from_buf_q  <= hit;
      end else if (mem_hs) begin
        issue_cnt_q <= issue_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      base_q <= in_req_addr_i & LINE_MASK;
      id_q   <= in_req_id_i;
    end
  end

  snitch_icache_line_assembler #(
    .LINE_WIDTH (LINE_WIDTH),
    .MEM_DW     (MEM_DW)
  ) i_assembler (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (req_hs),
    .beat_valid_i (beat_valid),
    .beat_data_i  (mem_rsp_data_i),
    .beat_error_i (mem_rsp_error_i),
    .line_o       (line),
    .error_o      (line_error),
    .last_o       (beat_last)
  );

`ifdef SNITCH_ICACHE_REFILL_LINE_BUF_EN
  localparam int unsigned TAG_W = FETCH_AW - LINE_ALIGN;

  logic             buf_valid_q, fill_ok_q, fill_done_q, buf_write;
  logic [TAG_W-1:0] buf_tag_q;
  logic [LINE_WIDTH-1:0] buf_data_q;

  assign hit       = buf_valid_q && !flush_i &&
                     (buf_tag_q == in_req_addr_i[FETCH_AW-1:LINE_ALIGN]);
  assign buf_data  = buf_data_q;
  // The final beat's error only lands one cycle after fill_done, so commit then.
  assign buf_write = fill_done_q && fill_ok_q && !line_error && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      fill_ok_q   <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= fill_done;
      if (req_hs)       fill_ok_q <= !hit;
      else if (flush_i) fill_ok_q <= 1'b0;
      if (flush_i)        buf_valid_q <= 1'b0;
      else if (buf_write) buf_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_write) begin
      buf_tag_q  <= base_q[FETCH_AW-1:LINE_ALIGN];
      buf_data_q <= line;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign hit          = 1'b0;
  assign buf_data     = '0;
`endif

  assign in_req_ready_o  = (state_q == IDLE);
  assign mem_req_valid_o = (state_q == FETCH) && (issue_cnt_q < CW'(BEATS));
  assign mem_req_addr_o  = (state_q == FETCH) ?
                           base_q + (FETCH_AW'(issue_cnt_q) << BEAT_ALIGN) : '0;
  assign in_rsp_valid_o  = (state_q == RESP);
  assign in_rsp_data_o   = (state_q == RESP) ? (from_buf_q ? buf_data : line) : '0;
  assign in_rsp_error_o  = (state_q == RESP) && !from_buf_q && line_error;
  assign in_rsp_id_o     = (state_q == RESP) ? id_q : '0;

  // Handshake protocol checks against the previous cycle's stalled transfer.
  logic                  req_pend_q, rsp_pend_q;
  logic [FETCH_AW-1:0]   req_addr_q;
  logic [ID_WIDTH-1:0]   req_id_q, rsp_id_q;
  logic [LINE_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pend_q <= 1'b0;
      rsp_pend_q <= 1'b0;
    end else begin
      req_pend_q <= in_req_valid_i && !in_req_ready_o;
      rsp_pend_q <= in_rsp_valid_o && !in_rsp_ready_i;
    end
    req_addr_q <= in_req_addr_i;
    req_id_q   <= in_req_id_i;
    rsp_data_q <= in_rsp_data_o;
    rsp_id_q   <= in_rsp_id_o;
    rsp_err_q  <= in_rsp_error_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (req_pend_q)
        assert (in_req_valid_i && in_req_addr_i == req_addr_q && in_req_id_i == req_id_q);
      if (rsp_pend_q)
        assert (in_rsp_valid_o && in_rsp_data_o == rsp_data_q &&
                in_rsp_id_o == rsp_id_q && in_rsp_error_o == rsp_err_q);
      assert (!(mem_rsp_valid_i && state_q != FETCH));
    end
  end

endmodule

// File: tb/tb_snitch_icache_l0_refill_server.sv
// Scoreboard bench for the L0 refill server: stimulus pushes expected memory
// addresses and line responses; monitor processes pop and compare them.
module tb_snitch_icache_l0_refill_server;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  in_req_addr_i;
  logic [1:0]   in_req_id_i;
  logic         in_req_valid_i, in_req_ready_o;
  logic [127:0] in_rsp_data_o;
  logic         in_rsp_error_o;
  logic [1:0]   in_rsp_id_o;
  logic         in_rsp_valid_o, in_rsp_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_req_valid_o, mem_req_ready_i;
  logic [31:0]  mem_rsp_data_i;
  logic         mem_rsp_error_i, mem_rsp_valid_i;
  logic         flush_i;

  always #5 clk = ~clk;

  snitch_icache_l0_refill_server dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_req_addr_i(in_req_addr_i), .in_req_id_i(in_req_id_i),
    .in_req_valid_i(in_req_valid_i), .in_req_ready_o(in_req_ready_o),
    .in_rsp_data_o(in_rsp_data_o), .in_rsp_error_o(in_rsp_error_o),
    .in_rsp_id_o(in_rsp_id_o), .in_rsp_valid_o(in_rsp_valid_o),
    .in_rsp_ready_i(in_rsp_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_error_i(mem_rsp_error_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .flush_i(flush_i)
  );

  typedef struct {
    logic [127:0] data;
    logic [1:0]   id;
    logic         err;
  } rsp_t;

  rsp_t        exp_rsp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] mem_data [logic [31:0]];
  logic        mem_err  [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int rsp_count = 0;
  bit rdy_toggle = 0;
  bit rand_lat = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Memory model: in-order responses with 1..4 cycle latency, dropped on reset.
  initial begin
    logic [31:0] pend_a[$];
    int          pend_due[$];
    logic [31:0] a;
    logic [3:0]  rdy_pat;
    bit          hs, rst_seen;
    int          rdy_idx, lat;
    rdy_pat = 4'b1001;
    rdy_idx = 0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_error_i = 1'b0;
    forever begin
      @(negedge clk);
      hs       = !rst_i && mem_req_valid_o && mem_req_ready_i;
      a        = mem_req_addr_o;
      rst_seen = rst_i;
      if (hs) begin
        hs_count++;
        if (exp_addr_q.size() == 0) check("mem_extra_req", {96'd0, a}, 128'hffff_ffff);
        else check("mem_req_addr", {96'd0, a}, {96'd0, exp_addr_q.pop_front()});
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rst_seen) begin
        pend_a.delete();
        pend_due.delete();
      end else if (hs) begin
        lat = rand_lat ? int'($urandom_range(1, 4)) : 1;
        pend_a.push_back(a);
        pend_due.push_back(cyc + lat - 1);
      end
      if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
        a = pend_a.pop_front();
        void'(pend_due.pop_front());
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = mem_data.exists(a) ? mem_data[a] : 32'hdead_0000;
        mem_rsp_error_i = mem_err.exists(a) ? mem_err[a] : 1'b0;
        rsp_count++;
      end else begin
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        mem_rsp_error_i = 1'b0;
      end
      if (rdy_toggle) begin
        mem_req_ready_i = rdy_pat[rdy_idx];
        rdy_idx = (rdy_idx + 1) % 4;
      end else begin
        mem_req_ready_i = 1'b1;
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && in_rsp_valid_o && in_rsp_ready_i) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_extra", {127'd0, in_rsp_valid_o}, 128'd0);
        end else begin
          e = exp_rsp_q.pop_front();
          check("rsp_data", in_rsp_data_o, e.data);
          check("rsp_id", {126'd0, in_rsp_id_o}, {126'd0, e.id});
          check("rsp_error", {127'd0, in_rsp_error_o}, {127'd0, e.err});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic set_beat(input logic [31:0] a, input logic [31:0] d, input logic e);
    mem_data[a] = d;
    mem_err[a]  = e;
  endtask

  task automatic expect_fetch(input logic [31:0] base);
    for (int b = 0; b < 4; b++) exp_addr_q.push_back(base + 32'(b * 4));
  endtask

  task automatic expect_rsp(input logic [127:0] d, input logic [1:0] id, input logic err);
    rsp_t r;
    r.data = d;
    r.id   = id;
    r.err  = err;
    exp_rsp_q.push_back(r);
  endtask

  task automatic send_req(input logic [31:0] a, input logic [1:0] id);
    int n;
    @(posedge clk); #1;
    in_req_valid_i = 1'b1;
    in_req_addr_i  = a;
    in_req_id_i    = id;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_req_ready_o) break;
      n++;
      if (n > 200) begin
        check("req_accept_timeout", 128'd0, 128'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_rsp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, {127'd0, exp_rsp_q.size() == 0}, 128'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, hs0, r0;
    rst_i = 1'b1;
    in_req_valid_i = 1'b0;
    in_req_addr_i  = '0;
    in_req_id_i    = '0;
    in_rsp_ready_i = 1'b1;
    flush_i        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {127'd0, in_req_ready_o}, 128'd1);
    check("rst_rsp_valid", {127'd0, in_rsp_valid_o}, 128'd0);
    check("rst_mem_valid", {127'd0, mem_req_valid_o}, 128'd0);
    check("rst_rsp_data", in_rsp_data_o, 128'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // 1: basic refill, unaligned address
    set_beat(32'h1000_0010, 32'hA, 1'b0);
    set_beat(32'h1000_0014, 32'hB, 1'b0);
    set_beat(32'h1000_0018, 32'hC, 1'b0);
    set_beat(32'h1000_001C, 32'hD, 1'b0);
    expect_fetch(32'h1000_0010);
    expect_rsp(128'h0000000D_0000000C_0000000B_0000000A, 2'd2, 1'b0);
    send_req(32'h1000_0014, 2'd2);
    wait_done("t1_done");

    // 2: error on beat 2, then a clean line clears the flag
    set_beat(32'h2000_0000, 32'h1, 1'b0);
    set_beat(32'h2000_0004, 32'h2, 1'b0);
    set_beat(32'h2000_0008, 32'h3, 1'b1);
    set_beat(32'h2000_000C, 32'h4, 1'b0);
    expect_fetch(32'h2000_0000);
    expect_rsp(128'h00000004_00000003_00000002_00000001, 2'd1, 1'b1);
    send_req(32'h2000_0000, 2'd1);
    wait_done("t2_err_done");
    set_beat(32'h2000_0040, 32'h5, 1'b0);
    set_beat(32'h2000_0044, 32'h6, 1'b0);
    set_beat(32'h2000_0048, 32'h7, 1'b0);
    set_beat(32'h2000_004C, 32'h8, 1'b0);
    expect_fetch(32'h2000_0040);
    expect_rsp(128'h00000008_00000007_00000006_00000005, 2'd3, 1'b0);
    send_req(32'h2000_0040, 2'd3);
    wait_done("t2_clean_done");

    // 3: response backpressure, queued request waits for the handshake
    for (int b = 0; b < 4; b++) begin
      set_beat(32'h3000_0000 + 32'(b * 4), 32'h11 + 32'(b * 16'h11), 1'b0);
      set_beat(32'h3000_0100 + 32'(b * 4), 32'h21 + 32'(b), 1'b0);
    end
    in_rsp_ready_i = 1'b0;
    expect_fetch(32'h3000_0000);
    expect_rsp(128'h00000044_00000033_00000022_00000011, 2'd0, 1'b0);
    send_req(32'h3000_0000, 2'd0);
    n = 0;
    while (!in_rsp_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    expect_fetch(32'h3000_0100);
    expect_rsp(128'h00000024_00000023_00000022_00000021, 2'd3, 1'b0);
    in_req_valid_i = 1'b1;
    in_req_addr_i  = 32'h3000_0100;
    in_req_id_i    = 2'd3;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_valid", {127'd0, in_rsp_valid_o}, 128'd1);
      check("t3_hold_data", in_rsp_data_o, 128'h00000044_00000033_00000022_00000011);
      check("t3_hold_id", {126'd0, in_rsp_id_o}, 128'd0);
      check("t3_req_blocked", {127'd0, in_req_ready_o}, 128'd0);
    end
    @(posedge clk); #1;
    in_rsp_ready_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_req_ready_o) break;
      n++;
      if (n > 50) begin
        check("t3_accept_timeout", 128'd0, 128'd1);
        break;
      end
    end
    check("t3_no_overlap", {127'd0, in_rsp_valid_o}, 128'd0);
    @(posedge clk); #1;
    in_req_valid_i = 1'b0;
    wait_done("t3_done");

    // 4: stalling memory request port, random response spacing
    for (int b = 0; b < 4; b++) set_beat(32'h4000_0020 + 32'(b * 4), 32'h41 + 32'(b), 1'b0);
    rdy_toggle = 1;
    rand_lat   = 1;
    hs0 = hs_count;
    expect_fetch(32'h4000_0020);
    expect_rsp(128'h00000044_00000043_00000042_00000041, 2'd1, 1'b0);
    send_req(32'h4000_002C, 2'd1);
    wait_done("t4_done");
    repeat (4) @(negedge clk);
    check("t4_mem_req_count", 128'(hs_count - hs0), 128'd4);
    rdy_toggle = 0;
    rand_lat   = 0;

    // 5: reset in the middle of a fetch
    for (int b = 0; b < 4; b++) set_beat(32'h5000_0000 + 32'(b * 4), 32'h51 + 32'(b), 1'b0);
    expect_fetch(32'h5000_0000);
    r0 = rsp_count;
    send_req(32'h5000_0000, 2'd2);
    n = 0;
    while (rsp_count < r0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_addr_q.delete();
    @(negedge clk);
    check("t5_req_ready", {127'd0, in_req_ready_o}, 128'd1);
    check("t5_rsp_valid", {127'd0, in_rsp_valid_o}, 128'd0);
    check("t5_mem_valid", {127'd0, mem_req_valid_o}, 128'd0);
    check("t5_mem_addr", {96'd0, mem_req_addr_o}, 128'd0);
    check("t5_rsp_data", in_rsp_data_o, 128'd0);
    check("t5_rsp_id_err", {125'd0, in_rsp_id_o, in_rsp_error_o}, 128'd0);
    expect_fetch(32'h5000_0000);
    expect_rsp(128'h00000054_00000053_00000052_00000051, 2'd3, 1'b0);
    send_req(32'h5000_0008, 2'd3);
    wait_done("t5_after_reset_done");

`ifdef SNITCH_ICACHE_REFILL_LINE_BUF_EN
    // 6: buffered line hit, then flush forces a refetch
    hs0 = hs_count;
    expect_rsp(128'h00000054_00000053_00000052_00000051, 2'd1, 1'b0);
    send_req(32'h5000_0004, 2'd1);
    @(negedge clk);
    check("t6_hit_valid", {127'd0, in_rsp_valid_o}, 128'd1);
    wait_done("t6_hit_done");
    check("t6_hit_no_mem", 128'(hs_count - hs0), 128'd0);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    hs0 = hs_count;
    expect_fetch(32'h5000_0000);
    expect_rsp(128'h00000054_00000053_00000052_00000051, 2'd1, 1'b0);
    send_req(32'h5000_0004, 2'd1);
    wait_done("t6_flush_done");
    check("t6_flush_mem", 128'(hs_count - hs0), 128'd4);
`endif

    repeat (3) @(negedge clk);
    check("addr_queue_empty", 128'(exp_addr_q.size()), 128'd0);
    check("rsp_queue_empty", 128'(exp_rsp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
